// File: rtl/pdm_audio_tx_if.sv
// Sample handshake between the playback controller and the PDM transmitter.
interface pdm_audio_tx_if #(
    parameter int SAMPLE_W = 16
);
    logic [SAMPLE_W-1:0] sample_i;
    logic                sample_valid_i;
    logic                sample_ready_o;

    modport master (output sample_i, output sample_valid_i, input sample_ready_o);
    modport slave  (input sample_i, input sample_valid_i, output sample_ready_o);
endinterface

// File: rtl/pdm_audio_tx.sv
// PCM-to-PDM playback transmitter: one-entry sample buffer feeding a
// first-order sigma-delta modulator clocked at the PDM bit rate.
//   state | meaning
//   IDLE  | outputs low, all datapath registers held at zero
//   RUN   | amplifier on, bit/sample timing running, accepting samples
module pdm_audio_tx #(
    parameter int CLK_DIV  = 40,
    parameter int OSR      = 64,
    parameter int SAMPLE_W = 16
) (
    input  logic            clock_i,
    input  logic            Reset,
    input  logic            enable_i,
    pdm_audio_tx_if.slave   smp,
    output logic            pdm_audio_o,
    output logic            pdm_sdaudio_o,
    output logic            underrun_o
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(OSR - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q,    state_d;
    logic [DIV_W-1:0]    div_cnt_q,  div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q,  bit_cnt_d;
    logic [SAMPLE_W-1:0] acc_q,      acc_d;
    logic [SAMPLE_W-1:0] cur_q,      cur_d;
    logic [SAMPLE_W-1:0] buf_q,      buf_d;
    logic                buf_full_q, buf_full_d;
    logic                pdm_q,      pdm_d;
    logic                sd_q,       sd_d;
    logic                ready_q,    ready_d;
    logic                underrun_q, underrun_d;

    logic                tick;
    logic                boundary;
    logic                take;
    logic [SAMPLE_W:0]   sum;

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        acc_d      = acc_q;
        cur_d      = cur_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        pdm_d      = pdm_q;
        sd_d       = sd_q;
        ready_d    = ready_q;
        underrun_d = 1'b0;

        tick     = (div_cnt_q == DIV_MAX);
        boundary = tick && (bit_cnt_q == BIT_MAX);
        take     = smp.sample_valid_i && ready_q;
        // MSB flip turns the signed sample into offset binary before accumulating
        sum      = {1'b0, acc_q} + {1'b0, ~cur_q[SAMPLE_W-1], cur_q[SAMPLE_W-2:0]};

        if (state_q == RUN && enable_i) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
            if (tick) begin
                bit_cnt_d = boundary ? '0 : bit_cnt_q + BIT_W'(1);
                acc_d     = sum[SAMPLE_W-1:0];
                pdm_d     = sum[SAMPLE_W];
            end
            if (boundary) begin
                if (buf_full_q) begin
                    cur_d      = buf_q;
                    buf_full_d = 1'b0;
                end else begin
                    cur_d      = '0;
                    underrun_d = 1'b1;
                end
            end
            // take implies the buffer was empty, so it never collides with the refill above
            if (take) begin
                buf_d      = smp.sample_i;
                buf_full_d = 1'b1;
            end
            ready_d = !buf_full_d;
            sd_d    = 1'b1;
        end else begin
            state_d    = IDLE;
            div_cnt_d  = '0;
            bit_cnt_d  = '0;
            acc_d      = '0;
            cur_d      = '0;
            buf_d      = '0;
            buf_full_d = 1'b0;
            pdm_d      = 1'b0;
            sd_d       = 1'b0;
            ready_d    = 1'b0;
            if (enable_i) begin
                state_d = RUN;
                sd_d    = 1'b1;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            acc_q      <= '0;
            cur_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            pdm_q      <= 1'b0;
            sd_q       <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            acc_q      <= acc_d;
            cur_q      <= cur_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            pdm_q      <= pdm_d;
            sd_q       <= sd_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign pdm_audio_o        = pdm_q;
    assign pdm_sdaudio_o      = sd_q;
    assign underrun_o         = underrun_q;
    assign smp.sample_ready_o = ready_q;
endmodule

// File: doc/pdm_audio_tx.md
# pdm_audio_tx

Playback-side PDM transmitter for the audio recorder: accepts signed PCM samples from the clip memory read path through a valid/ready handshake and converts them to a 1-bit pulse-density stream on the board's mono audio output. It is the transmit counterpart of the microphone PDM capture path. It sits between the playback controller (sample source) and the top-level pins `pdm_audio_o` and `pdm_sdaudio_o`.

## Interface
- `CLK_DIV`, 40, system clocks per PDM bit; 100 MHz / 40 = 2.5 MHz bit rate; must be ≥ 2
- `OSR`, 64, PDM bits per PCM sample; 2.5 MHz / 64 = 39.0625 kHz sample rate; must be ≥ 2
- `SAMPLE_W`, 16, PCM sample width, two's complement
- `clock_i`  in  1  system clock, 100 MHz
- `Reset`  in  1  asynchronous, active-high reset
- `enable_i`  in  1  playback enable from controller; level-sensitive
- `sample_i`  in  SAMPLE_W  signed PCM sample
- `sample_valid_i`  in  1  `sample_i` is valid
- `sample_ready_o`  out  1  holding buffer empty; sample accepted when valid & ready
- `pdm_audio_o`  out  1  PDM bit stream to the audio low-pass filter
- `pdm_sdaudio_o`  out  1  amplifier enable; 1 = amplifier on
- `underrun_o`  out  1  one-cycle pulse: sample boundary reached with empty buffer

## Operation
- State machine: IDLE, RUN.
- IDLE:
  - all outputs 0
  - `div_cnt`, `bit_cnt`, accumulator, current sample and buffer cleared
  - `enable_i` = 1 → RUN next cycle
- RUN:
  - `pdm_sdaudio_o` = 1
  - `enable_i` = 0 → IDLE next cycle; buffered and current samples discarded; no underrun pulse
- Handshake:
  - one-entry holding buffer
  - `sample_ready_o` = RUN & buffer empty
  - transfer when `sample_valid_i` & `sample_ready_o`: buffer ← `sample_i`, full; `sample_ready_o` drops the next cycle
  - `sample_i` is ignored when not ready
- Counters:
  - `div_cnt` counts 0..CLK_DIV-1; bit tick when `div_cnt` = CLK_DIV-1
  - `bit_cnt` advances on each bit tick, 0..OSR-1, wraps to 0
  - sample boundary = bit tick with `bit_cnt` = OSR-1
- Sample boundary:
  - buffer full: current ← buffer, buffer empty; `sample_ready_o` rises the next cycle
  - buffer empty: current ← 0 (silence); `underrun_o` pulses for that cycle
  - valid & ready on the boundary cycle: sample goes to the buffer, not to current; underrun is still flagged, and the sample plays in the following period
  - current sample is 0 on entering RUN, so the first period is silence
- Modulator (first-order sigma-delta, one update per bit tick):
  - u = current with MSB inverted (offset binary)
  - {carry, acc} = acc + u; SAMPLE_W-bit accumulator, carry is bit SAMPLE_W
  - `pdm_audio_o` ← carry
  - ones density = u / 2^SAMPLE_W: 0x8000 → all 0; 0x0000 → 50 %; 0x7FFF → 65535/65536
  - no saturation needed; modular wrap is the intended behaviour
- `Reset` asserted, at any time: immediate IDLE with all registers cleared, independent of `clock_i`.

## Timing
- All outputs are registered.
- Reset values: `pdm_audio_o` 0, `pdm_sdaudio_o` 0, `sample_ready_o` 0, `underrun_o` 0.
- Entering RUN:
  - `pdm_sdaudio_o` and `sample_ready_o` go high in the first RUN cycle
  - first bit tick occurs CLK_DIV cycles after entering RUN
- Bit stream:
  - `pdm_audio_o` changes only in the cycle after a bit tick
  - each bit is held exactly CLK_DIV cycles
- Sample period = CLK_DIV × OSR = 2560 cycles. A sample accepted anywhere in period n plays in period n+1.
- Throughput: at most one accepted sample per sample period once the buffer is full.
- `underrun_o` is high for exactly one cycle per starved boundary.

## Test plan
- Reset:
  - assert `Reset` mid-RUN with buffer full → same cycle: all outputs 0
  - after release with `enable_i` = 1 → RUN; first bit tick after 40 cycles
- Silence:
  - enable, feed 0x0000 continuously → from period 2, `pdm_audio_o` = 0,1,0,1… at 40-cycle bits
  - 32 ones per 64 bits
- Extremes:
  - feed 0x8000 → period of all-zero bits
  - feed 0x7FFF → first bit 0, remaining 63 bits 1
- Underrun:
  - accept one sample, then hold `sample_valid_i` low → `underrun_o` pulses once per 2560 cycles
  - output is 50 % density
- Back-pressure:
  - `sample_valid_i` held high with incrementing data → exactly one transfer per 2560 cycles
  - `sample_ready_o` low between boundaries; no sample lost or duplicated
- Disable mid-period:
  - drop `enable_i` at `bit_cnt` = 20 → next cycle `pdm_sdaudio_o` = 0, `pdm_audio_o` = 0, `sample_ready_o` = 0
  - re-enable → first period is silence
